// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC and runs a single-outstanding
// req/gnt/rvalid handshake, presenting one instruction at a time to IF/ID.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc4,
    output logic [31:0]       if_inst
);

    typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              kill_q, kill_d;
    logic              if_valid_q, if_valid_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [31:0]       if_inst_q, if_inst_d;
    logic [ADDR_W-1:0] target_pc;

    assign target_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StReq;
            fetch_pc_q <= RESET_PC[ADDR_W-1:0];
            kill_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            kill_q     <= kill_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        unique case (state_q)
            StReq: begin
                if (imem_gnt) begin
                    state_d = StWait;
                    if (redirect) begin
                        kill_d     = 1'b1;
                        fetch_pc_d = target_pc;
                    end
                end else if (redirect) begin
                    fetch_pc_d = target_pc;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    if (kill_q || redirect) begin
                        // Stale response: drop it and refetch from the new PC.
                        kill_d  = 1'b0;
                        state_d = StReq;
                        if (redirect) fetch_pc_d = target_pc;
                    end else begin
                        if_inst_d  = imem_rdata;
                        if_pc_d    = fetch_pc_q;
                        if_valid_d = 1'b1;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                        state_d    = StHold;
                    end
                end else if (redirect) begin
                    kill_d     = 1'b1;
                    fetch_pc_d = target_pc;
                end
            end
            StHold: begin
                // Redirect wins over stall.
                if (redirect) begin
                    if_valid_d = 1'b0;
                    fetch_pc_d = target_pc;
                    state_d    = StReq;
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                    state_d    = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    assign imem_req  = rst && (state_q == StReq);
    assign imem_addr = fetch_pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_pc4    = if_pc_q + ADDR_W'(4);
    assign if_inst   = if_inst_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl; expected IF outputs are queued when a
// response is driven and popped when if_valid appears.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_inst;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_valid_cyc;
    int   prev_valid_cyc;

    if_fetch_ctrl #(
        .RESET_PC(32'h0000_0000),
        .ADDR_W  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_pc4     (if_pc4),
        .if_inst    (if_inst)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // From a REQ-ready point, fetch one word and stop at the negedge in HOLD.
    task automatic fetch_to_hold(input logic [31:0] addr, input logic [31:0] inst);
        exp_t e;
        for (int i = 0; i < 10 && !imem_req; i++) step();
        chk("req_wait", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, addr);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("wait_req", {31'd0, imem_req}, 32'd0);
        chk("wait_valid", {31'd0, if_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = inst;
        sb.push_back('{pc: addr, inst: inst});
        step();
        imem_rvalid = 1'b0;
        chk("hold_valid", {31'd0, if_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("if_pc", if_pc, e.pc);
            chk("if_pc4", if_pc4, e.pc + 32'd4);
            chk("if_inst", if_inst, e.inst);
        end
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
    endtask

    // Hold for some stall cycles, then let IF/ID consume.
    task automatic release_hold(input int stall_cycles);
        logic [31:0] pc_s, inst_s;
        pc_s   = if_pc;
        inst_s = if_inst;
        stall  = 1'b1;
        for (int i = 0; i < stall_cycles; i++) begin
            step();
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_pc", if_pc, pc_s);
            chk("stall_inst", if_inst, inst_s);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        step();
        chk("consume_valid", {31'd0, if_valid}, 32'd0);
        chk("consume_req", {31'd0, imem_req}, 32'd1);
        chk("consume_addr", imem_addr, pc_s + 32'd4);
    endtask

    initial begin
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        last_valid_cyc = 0;
        prev_valid_cyc = 0;

        // Reset values; no request while held in reset.
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        step();
        chk("rst_req2", {31'd0, imem_req}, 32'd0);
        step();
        rst = 1'b1;
        #1;
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);

        // Back-to-back sequential fetch, one every 3 cycles.
        fetch_to_hold(32'h0, 32'h0000_0013);
        release_hold(0);
        fetch_to_hold(32'h4, 32'h0010_0093);
        chk("throughput", 32'(last_valid_cyc - prev_valid_cyc), 32'd3);
        release_hold(0);

        // Stall for 3 cycles in HOLD.
        fetch_to_hold(32'h8, 32'h0000_0013);
        release_hold(3);

        // Redirect in WAIT, stale response two cycles later.
        chk("redir_addr0", imem_addr, 32'hC);
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk("kill_req", {31'd0, imem_req}, 32'd0);
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("stale_valid", {31'd0, if_valid}, 32'd0);
        chk("stale_req", {31'd0, imem_req}, 32'd1);
        chk("stale_addr", imem_addr, 32'h100);
        fetch_to_hold(32'h100, 32'h0020_0113);
        release_hold(0);

        // Redirect and stall together in HOLD; low target bits dropped.
        fetch_to_hold(32'h104, 32'h0030_0193);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        chk("rs_valid", {31'd0, if_valid}, 32'd0);
        chk("rs_req", {31'd0, imem_req}, 32'd1);
        chk("rs_addr", imem_addr, 32'h200);

        // Redirect in REQ to the top word, then fetch across the wrap.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        fetch_to_hold(32'hFFFF_FFFC, 32'h0040_0213);
        release_hold(0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Async reset mid-WAIT.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_valid", {31'd0, if_valid}, 32'd0);
        chk("async_pc", if_pc, 32'd0);
        step();
        rst = 1'b1;
        #1;
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h0);
        // In-flight response arriving in REQ is ignored.
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        step();
        imem_rvalid = 1'b0;
        chk("late_valid", {31'd0, if_valid}, 32'd0);
        chk("late_req", {31'd0, imem_req}, 32'd1);
        chk("late_inst", if_inst, 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
